rstack_ctrl: RTL
================

# rstack_ctrl

Self-managing, parametrised return stack for the CPU core. Unlike a bare register file driven by external addresses, it owns its stack pointer and exposes push, pop and replace (push+pop) operations. It also provides a combinational top-of-stack output, full/empty status, and sticky overflow/underflow error flags. It sits beside the control unit and holds return addresses for CALL/RET; its width and depth are sized per build.

## Interface
- DATA_WIDTH, 13, width of one stack entry (return address).
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- PTR_WIDTH, $clog2(DEPTH), derived localparam; not overridable.

- clk  in  1  single system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  push din (or replace top when pop is also high).
- pop  in  1  discard top entry.
- din  in  DATA_WIDTH  data to push or replace.
- clear_err  in  1  synchronous clear of the sticky error flags.
- tos  out  DATA_WIDTH  current top entry; forced to 0 when empty.
- count  out  PTR_WIDTH+1  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky flag: a push was rejected because the stack was full.
- underflow  out  1  sticky flag: a pop or replace was rejected because the stack was empty.

## Operation
- Storage: DEPTH x DATA_WIDTH array with a synchronous write and an asynchronous read. The array is not reset; only the control state is.
- count register is PTR_WIDTH+1 bits, so DEPTH is representable. Write index and top index use the low PTR_WIDTH bits (count and count-1 respectively).
- Each cycle is decoded by {push, pop}:
  - 00 idle: no state change.
  - 10 push: if !full, write mem[count] <= din and count <= count+1. If full, nothing is written, count is held, and overflow <= 1.
  - 01 pop: if !empty, count <= count-1; the entry is not cleared. If empty, count is held and underflow <= 1.
  - 11 replace: if !empty, write mem[count-1] <= din and hold count. If empty, nothing is written, count is held, and underflow <= 1. Replace never overflows, even when full.
- tos = empty ? 0 : mem[count-1]. The read is combinational from the registered count and the array contents.
- empty and full are decoded combinationally from count.
- clear_err clears both sticky flags. If an error event occurs in the same cycle, set wins and the flag stays 1.
- A rejected operation never corrupts count or memory. The error flags only report.

## Timing
- Reset (asynchronous, while reset=1): count=0, overflow=0, underflow=0, so empty=1, full=0, tos=0. Inputs are ignored until the first rising clk edge after reset deasserts.
- Reset asserted mid-operation forces the reset state immediately, with no clock needed. Array contents are undefined afterwards, but tos is still 0 because empty=1.
- Latency:
  - An operation sampled at edge N is reflected in count, empty, full, tos and the flags after edge N.
  - There is no same-cycle bypass. din is visible on tos only the cycle after the push or replace.
- Throughput: one operation per cycle, every cycle. Back-to-back push/pop sequences and alternating push/replace sequences are legal.
- Wrap-around: addressing never wraps. Push at count==DEPTH is rejected, and pop at count==0 is rejected.

## Test plan
- Reset check: assert reset asynchronously between clock edges -> count=0, empty=1, full=0, tos=0, overflow=0, underflow=0 immediately. Then push 0x0A1, 0x0B2, 0x0C3 on consecutive cycles -> tos reads 0x0A1, 0x0B2, 0x0C3 and count reads 1, 2, 3 on the following cycles.
- Fill and overflow (DEPTH=16): push values 1..16 -> full=1, tos=16. Push 0x1FF -> overflow=1, count=16, tos=16. Pop 16 times -> tos walks 15..1 then 0, empty=1, underflow=0.
- Underflow: from reset, pop -> underflow=1, count=0. Replace on empty -> underflow stays 1 and tos=0. Push 5 -> tos=5, count=1, showing state is not corrupted.
- Replace: push 0x010, push 0x020, then push+pop with din=0x030 -> count=2, tos=0x030. Pop -> tos=0x010. Repeat the replace at full -> overflow stays 0.
- Sticky flag clearing: set overflow, then pulse clear_err -> overflow=0 next cycle. Assert clear_err in the same cycle as a push at full -> overflow=1.
- Reset mid-stream: with count=7, assert reset for a partial cycle -> count=0 and tos=0 without a clock edge. After release, push 0x123 -> tos=0x123, count=1.

Source files
------------

// File: rtl/rstack_ctrl.sv
// Return stack for CALL/RET with an internal stack pointer, push/pop/replace,
// combinational top-of-stack and sticky overflow/underflow flags.
module rstack_ctrl #(
    parameter int DATA_WIDTH = 13,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          clear_err,
    output logic [DATA_WIDTH-1:0]         tos,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty,
    output logic                          full,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_WIDTH:0]   count_m1;
    logic [PTR_WIDTH-1:0] wr_idx;
    logic [PTR_WIDTH-1:0] top_idx;
    logic [PTR_WIDTH-1:0] wr_addr;
    logic                 do_push;
    logic                 do_pop;
    logic                 do_repl;
    logic                 wr_en;
    logic                 err_ovf;
    logic                 err_unf;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_WIDTH+1)'(DEPTH));
    assign count_m1 = count - (PTR_WIDTH+1)'(1);
    assign wr_idx   = count[PTR_WIDTH-1:0];
    assign top_idx  = count_m1[PTR_WIDTH-1:0];

    assign do_push = push && !pop && !full;
    assign do_pop  = pop && !push && !empty;
    assign do_repl = push && pop && !empty;
    assign err_ovf = push && !pop && full;
    // Both plain pop and replace are rejected on an empty stack.
    assign err_unf = pop && empty;

    assign wr_en   = do_push || do_repl;
    assign wr_addr = pop ? top_idx : wr_idx;

    assign tos = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    // An error event in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) begin
                count <= count + (PTR_WIDTH+1)'(1);
            end else if (do_pop) begin
                count <= count_m1;
            end

            if (err_ovf) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end

            if (err_unf) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
